hazard_scoreboard: RTL
======================

# hazard_scoreboard

Centralised hazard controller for the five-stage MIPS pipeline. It tracks the destination register and remaining result latency (Tnew) of every instruction in E, M and W. Each cycle it compares these against the source registers and use deadlines (Tuse) of the instruction in D, then drives the stall and forwarding selects for the D and E stages. It replaces the per-stage ad-hoc stall logic, and optionally sequences the multiply/divide unit's busy window.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu
- DIV_CYCLES, 10, busy cycles loaded for div/divu

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- d_valid  in  1  D holds a real instruction; 0 = treat as bubble
- d_rs, d_rt  in  5 each  D source registers
- d_tuse_rs, d_tuse_rt  in  2 each  Tuse of each source; 3 = source unused
- d_waddr  in  5  D destination register; 0 = no write
- d_tnew  in  2  Tnew at D (jal 1, ALU 2, load 3)
- d_md_start  in  1  D is mult/multu/div/divu
- d_md_div  in  1  with d_md_start: divide
- d_is_md  in  1  D uses HI/LO or MDU (mult/div/mfhi/mflo/mthi/mtlo)
- stall  out  1  freeze PC and F/D; insert bubble into E
- fwd_d_rs, fwd_d_rt  out  2 each  D operand select: 0 RF, 1 M, 2 W
- fwd_e_rs, fwd_e_rt  out  2 each  E operand select: 0 pipeline reg, 1 M, 2 W
- md_busy  out  1  MDU counter nonzero
- e_waddr, m_waddr, w_waddr  out  5 each  tracked destinations (debug)

## Operation
- State: E entry {rs, rt, waddr, tnew}, M entry {waddr, tnew}, W entry {waddr}; md_cnt (4 bit).
- Match(stage, r): r != 0 && stage waddr == r.
- Stall sources: Match(E, d_rs) && e_tnew > d_tuse_rs; same for M; same for d_rt. A source with Tuse 3 never stalls.
- MDU stall (macro only): d_valid && d_is_md && md_busy.
- stall = d_valid && (any stall source).
- fwd_d_x: 1 if Match(M, d_x) && m_tnew == 0; else 2 if Match(W, d_x); else 0. M has priority over W.
- fwd_e_x: the same rule applied to the stored e_rs/e_rt.
- Register 0 is never matched, stalled on or forwarded.
- Advance, every edge:
  - M <= {e_waddr, sat(e_tnew-1)}.
  - W <= m_waddr.
  - If stall or !d_valid, E <= all-zero bubble. Otherwise E <= {d_rs, d_rt, d_waddr, sat(d_tnew-1)}.
  - sat(x) clamps at 0.
- W tnew is always 0, so it is not stored.
- Example latencies: an ALU result reaches M with tnew 0. A load has tnew 2 in E, 1 in M and 0 in W.

## Timing
- stall and all fwd_* outputs are combinational from current state and D inputs, valid within the same cycle.
- State updates on posedge clk only.
- While reset is low, all state and md_cnt are 0 immediately, regardless of clk.
- Outputs under reset: stall 0, fwd_* 0, md_busy 0, *_waddr 0.
- Reset deasserted mid-stall: the pipeline resumes with an empty scoreboard and no residual stall.
- Stall lasts exactly until the producer's tnew in E/M drops to ≤ Tuse:
  - load followed by ALU consumer: 1 cycle;
  - ALU followed by beq/jr: 1 cycle;
  - load followed by beq: 2 cycles.
- Simultaneous matches on rs and rt are evaluated independently. Stall is the OR of both.

## Configuration
- HZ_MDU_EN defined:
  - md_cnt loads MULT_CYCLES or DIV_CYCLES on the edge where a d_md_start instruction advances into E.
  - md_cnt decrements each later cycle, saturating at 0.
  - md_busy = (md_cnt != 0); the MDU stall term is active.
  - A load and a decrement never coincide, because a start cannot advance while busy.
- HZ_MDU_EN undefined: d_md_start, d_md_div and d_is_md are ignored; md_busy is tied 0; no counter is synthesised.

## Test plan
- Reset low mid-stall (load r8 in E, consumer of r8 in D) → stall drops to 0 immediately. After release, all *_waddr read 0.
- lw r8 enters E, then add r9,r8,r8 (Tuse 1) in D:
  - stall = 1 for exactly 1 cycle;
  - next cycle fwd_e_rs = fwd_e_rt = 2 (forward from W).
- ori r3 in M (tnew 0), beq r3,r3 in D → fwd_d_rs = fwd_d_rt = 1, stall = 0. Same with r3 in W → selects 2.
- ALU writes r5 in M and in W simultaneously (consecutive writers) → fwd_d_rs = 1 (M priority).
- Writer to r0 in E with tnew 2, consumer of r0 with Tuse 0 → stall = 0, fwd = 0.
- HZ_MDU_EN: div advances, then mflo in D:
  - md_busy is high for 10 cycles; stall is high for exactly those cycles;
  - add in D during the busy window → no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Central hazard scoreboard for the 5-stage MIPS pipeline: Tnew/Tuse stall and D/E forwarding selects.
// Optional multiply/divide busy sequencing is enabled with the HZ_MDU_EN macro.
module hazard_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_waddr,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_is_md,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       md_busy,
  output logic [4:0] e_waddr,
  output logic [4:0] m_waddr,
  output logic [4:0] w_waddr
);

  logic [4:0] e_rs_q, e_rt_q, e_waddr_q, m_waddr_q, w_waddr_q;
  logic [1:0] e_tnew_q, m_tnew_q;
  logic [4:0] e_rs_d, e_rt_d, e_waddr_d;
  logic [1:0] e_tnew_d;
  logic       src_stall, md_stall, advance;

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] mw,
                                         input logic [1:0] mt, input logic [4:0] ww);
    if (r != 5'd0 && mw == r && mt == 2'd0) return 2'd1;
    if (r != 5'd0 && ww == r)               return 2'd2;
    return 2'd0;
  endfunction

  // A source stalls when a producer in E or M still needs more cycles than the consumer can wait.
  function automatic logic src_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                      input logic [4:0] ew, input logic [1:0] et,
                                      input logic [4:0] mw, input logic [1:0] mt);
    return (r != 5'd0) && ((ew == r && et > tuse) || (mw == r && mt > tuse));
  endfunction

  assign src_stall = src_hazard(d_rs, d_tuse_rs, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q)
                   | src_hazard(d_rt, d_tuse_rt, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q);
  assign stall   = d_valid && (src_stall || md_stall);
  assign advance = d_valid && !stall;

  assign fwd_d_rs = fwd_sel(d_rs,   m_waddr_q, m_tnew_q, w_waddr_q);
  assign fwd_d_rt = fwd_sel(d_rt,   m_waddr_q, m_tnew_q, w_waddr_q);
  assign fwd_e_rs = fwd_sel(e_rs_q, m_waddr_q, m_tnew_q, w_waddr_q);
  assign fwd_e_rt = fwd_sel(e_rt_q, m_waddr_q, m_tnew_q, w_waddr_q);

  assign e_waddr = e_waddr_q;
  assign m_waddr = m_waddr_q;
  assign w_waddr = w_waddr_q;

  always_comb begin
    e_rs_d    = 5'd0;
    e_rt_d    = 5'd0;
    e_waddr_d = 5'd0;
    e_tnew_d  = 2'd0;
    if (advance) begin
      e_rs_d    = d_rs;
      e_rt_d    = d_rt;
      e_waddr_d = d_waddr;
      e_tnew_d  = sat_dec(d_tnew);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs_q    <= 5'd0;
      e_rt_q    <= 5'd0;
      e_waddr_q <= 5'd0;
      e_tnew_q  <= 2'd0;
      m_waddr_q <= 5'd0;
      m_tnew_q  <= 2'd0;
      w_waddr_q <= 5'd0;
    end else begin
      e_rs_q    <= e_rs_d;
      e_rt_q    <= e_rt_d;
      e_waddr_q <= e_waddr_d;
      e_tnew_q  <= e_tnew_d;
      m_waddr_q <= e_waddr_q;
      m_tnew_q  <= sat_dec(e_tnew_q);
      w_waddr_q <= m_waddr_q;
    end
  end

`ifdef HZ_MDU_EN
  logic [3:0] md_cnt_q, md_cnt_d;

  // A start can only advance while the counter is idle, so load and decrement never collide.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (advance && d_md_start)
      md_cnt_d = d_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) md_cnt_q <= 4'd0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign md_busy  = (md_cnt_q != 4'd0);
  assign md_stall = d_is_md && md_busy;
`else
  logic unused_md;
  localparam int unused_cycles = MULT_CYCLES + DIV_CYCLES;
  assign unused_md = ^{d_md_start, d_md_div, d_is_md};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule
